// File: rtl/cache_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_access_arbiter_if
// Purpose  : Bundles the requester, subsystem and statistics signals of the
//            cache access arbiter.
//            master : requesters / subsystem / stats client side
//            slave  : the arbiter itself
// Signals  : req0/addr0, req1/addr1       requester inputs
//            ack0, ack1, rsp_hit, rsp_err  completion pulse and result
//            sub_req/sub_addr              request towards the subsystem
//            sub_done/sub_hit              subsystem completion and hit flag
//            clr_stats                     synchronous counter clear
//            access_cnt/hit_cnt            saturating statistics
//            busy                          arbiter not idle
// Revision : 1.0 - initial release
// ============================================================================
interface cache_access_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 16
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              ack0;
    logic              ack1;
    logic              rsp_hit;
    logic              rsp_err;
    logic              sub_req;
    logic [ADDR_W-1:0] sub_addr;
    logic              sub_done;
    logic              sub_hit;
    logic              clr_stats;
    logic [CNT_W-1:0]  access_cnt;
    logic [CNT_W-1:0]  hit_cnt;
    logic              busy;

    modport master (
        output req0, addr0, req1, addr1, sub_done, sub_hit, clr_stats,
        input  ack0, ack1, rsp_hit, rsp_err, sub_req, sub_addr,
               access_cnt, hit_cnt, busy
    );

    modport slave (
        input  req0, addr0, req1, addr1, sub_done, sub_hit, clr_stats,
        output ack0, ack1, rsp_hit, rsp_err, sub_req, sub_addr,
               access_cnt, hit_cnt, busy
    );
endinterface
`default_nettype wire

// File: rtl/cache_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_access_arbiter
// Purpose  : Round-robin front end for two requesters sharing the cache /
//            main-memory subsystem. Holds the winning address on the
//            subsystem until it completes, returns hit/miss to the winner,
//            aborts with an error after TIMEOUT busy cycles, and keeps
//            saturating access/hit counters.
// Ports    : clk  - system clock, rising edge
//            rst  - synchronous reset, active low
//            bus  - cache_access_arbiter_if.slave (requesters, subsystem,
//                   statistics, busy)
// Revision : 1.0 - initial release
// ============================================================================
module cache_access_arbiter #(
    parameter int ADDR_W  = 15,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  wire logic             clk,
    input  wire logic             rst,
    cache_access_arbiter_if.slave bus
);

    localparam int                c_tmr_w    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max  = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_last_grant;
    logic                r_grant_id;
    logic [c_tmr_w-1:0]  r_timer;
    logic                r_sub_req;
    logic [ADDR_W-1:0]   r_sub_addr;
    logic                r_ack0;
    logic                r_ack1;
    logic                r_rsp_hit;
    logic                r_rsp_err;
    logic                r_busy;
    logic [CNT_W-1:0]    r_access_cnt;
    logic [CNT_W-1:0]    r_hit_cnt;

    // Port 1 wins when it is the only requester, or when both request and
    // port 0 was the most recent winner.
    logic w_any_req;
    logic w_pick1;
    assign w_any_req = bus.req0 | bus.req1;
    assign w_pick1   = bus.req1 & (~bus.req0 | ~r_last_grant);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            r_timer      <= '0;
            r_sub_req    <= 1'b0;
            r_sub_addr   <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rsp_hit    <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_busy       <= 1'b0;
            r_access_cnt <= '0;
            r_hit_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant_id <= w_pick1;
                        r_sub_addr <= w_pick1 ? bus.addr1 : bus.addr0;
                        r_timer    <= '0;
                        r_sub_req  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    r_timer <= r_timer + 1'b1;
                    // A completion in the last allowed cycle is still a
                    // normal completion, so sub_done is tested first.
                    if (bus.sub_done || (r_timer == c_tmr_last)) begin
                        r_rsp_hit <= bus.sub_done & bus.sub_hit;
                        r_rsp_err <= ~bus.sub_done;
                        r_sub_req <= 1'b0;
                        r_ack0    <= ~r_grant_id;
                        r_ack1    <= r_grant_id;
                        r_state   <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    r_ack0       <= 1'b0;
                    r_ack1       <= 1'b0;
                    r_rsp_hit    <= 1'b0;
                    r_rsp_err    <= 1'b0;
                    r_busy       <= 1'b0;
                    r_last_grant <= r_grant_id;
                    r_state      <= ST_IDLE;
                end

                default: begin
                    r_sub_req <= 1'b0;
                    r_ack0    <= 1'b0;
                    r_ack1    <= 1'b0;
                    r_rsp_hit <= 1'b0;
                    r_rsp_err <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase

            // Statistics: a clear beats any increment in the same cycle;
            // timed-out accesses are not counted.
            if (bus.clr_stats) begin
                r_access_cnt <= '0;
                r_hit_cnt    <= '0;
            end else if ((r_state == ST_RESP) && !r_rsp_err) begin
                if (r_access_cnt != c_cnt_max) begin
                    r_access_cnt <= r_access_cnt + 1'b1;
                end
                if (r_rsp_hit && (r_hit_cnt != c_cnt_max)) begin
                    r_hit_cnt <= r_hit_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.ack0       = r_ack0;
    assign bus.ack1       = r_ack1;
    assign bus.rsp_hit    = r_rsp_hit;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.sub_req    = r_sub_req;
    assign bus.sub_addr   = r_sub_addr;
    assign bus.access_cnt = r_access_cnt;
    assign bus.hit_cnt    = r_hit_cnt;
    assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_cache_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_access_arbiter
// Purpose  : Self-checking bench for cache_access_arbiter. Expected responses
//            go into a scoreboard queue when a transaction is launched and
//            are popped when the matching ack appears; counters are checked
//            against a small saturating model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_access_arbiter;

    localparam int ADDR_W  = 15;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 64;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_access_arbiter_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    cache_access_arbiter #(
        .ADDR_W  (ADDR_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int   port;
        logic hit;
        logic err;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_acc     = 0;
    int   exp_hit     = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    // Queue an expected response and advance the counter model.
    task automatic push_exp(input int port, input logic hit, input logic err);
        exp_t e;
        e.port = port;
        e.hit  = hit;
        e.err  = err;
        sbq.push_back(e);
        if (!err) begin
            if (exp_acc < CNT_MAX) exp_acc++;
            if (hit && exp_hit < CNT_MAX) exp_hit++;
        end
    endtask

    task automatic await_ack(output int port, output logic hit, output logic err, output bit ok);
        ok = 1'b0; port = -1; hit = 1'b0; err = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
                port = (bus.ack1 === 1'b1) ? 1 : 0;
                hit  = bus.rsp_hit;
                err  = bus.rsp_err;
                ok   = 1'b1;
            end else begin
                tick();
            end
        end
    endtask

    task automatic await_sub_req(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            tick();
            if (bus.sub_req === 1'b1) ok = 1'b1;
        end
    endtask

    // Protocol monitor: acks are exclusive and results are quiet outside them.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            vectors++;
            if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) begin
                miscompares++;
                $display("FAIL ack_overlap: got ack0=%b ack1=%b, want at most one high", bus.ack0, bus.ack1);
            end else if (bus.ack0 !== 1'b1 && bus.ack1 !== 1'b1 &&
                         (bus.rsp_hit !== 1'b0 || bus.rsp_err !== 1'b0)) begin
                miscompares++;
                $display("FAIL rsp_outside_ack: got rsp_hit=%b rsp_err=%b, want 0 0", bus.rsp_hit, bus.rsp_err);
            end
        end
    end

    task automatic test_reset();
        int gp; logic gh, ge; bit ok; exp_t e;
        rst = 1'b0; bus.req0 = 1'b1; bus.addr0 = 15'h0123;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({bus.ack0, bus.ack1, bus.rsp_hit, bus.rsp_err, bus.sub_req, bus.busy} !== 6'b0 ||
                bus.sub_addr !== 15'h0 || bus.access_cnt !== 4'h0 || bus.hit_cnt !== 4'h0) begin
                miscompares++;
                $display("FAIL reset_outputs: got ack=%b%b rsp=%b%b sub_req=%b busy=%b addr=%h cnt=%0d/%0d, want all 0",
                         bus.ack0, bus.ack1, bus.rsp_hit, bus.rsp_err, bus.sub_req, bus.busy,
                         bus.sub_addr, bus.access_cnt, bus.hit_cnt);
            end
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (bus.sub_req !== 1'b1 || bus.sub_addr !== 15'h0123) begin
            miscompares++;
            $display("FAIL reset_release_grant: got sub_req=%b sub_addr=%h, want 1 0123", bus.sub_req, bus.sub_addr);
        end
        push_exp(0, 1'b0, 1'b0);
        bus.sub_done = 1'b1; bus.sub_hit = 1'b0;
        tick();
        bus.sub_done = 1'b0;
        await_ack(gp, gh, ge, ok);
        e = sbq.pop_front();
        vectors++;
        if (!ok || gp != e.port || gh !== e.hit || ge !== e.err) begin
            miscompares++;
            $display("FAIL reset_first_rsp: got ok=%0d port=%0d hit=%b err=%b, want port=%0d hit=%b err=%b",
                     ok, gp, gh, ge, e.port, e.hit, e.err);
        end
        bus.req0 = 1'b0;
        tick();
        vectors++;
        if (bus.access_cnt !== CNT_W'(exp_acc) || bus.hit_cnt !== CNT_W'(exp_hit)) begin
            miscompares++;
            $display("FAIL reset_counters: got %0d/%0d, want %0d/%0d", bus.access_cnt, bus.hit_cnt, exp_acc, exp_hit);
        end
    endtask

    task automatic test_single_hit();
        int gp; logic gh, ge; bit ok; exp_t e;
        bus.addr0 = 15'h1004; bus.req0 = 1'b1;
        tick();
        vectors++;
        if (bus.sub_req !== 1'b1 || bus.sub_addr !== 15'h1004) begin
            miscompares++;
            $display("FAIL hit_subreq: got sub_req=%b sub_addr=%h, want 1 1004", bus.sub_req, bus.sub_addr);
        end
        push_exp(0, 1'b1, 1'b0);
        bus.sub_done = 1'b1; bus.sub_hit = 1'b1;
        tick();
        bus.sub_done = 1'b0; bus.sub_hit = 1'b0;
        vectors++;
        if (bus.ack0 !== 1'b1) begin
            miscompares++;
            $display("FAIL hit_ack_latency: got ack0=%b two cycles after request, want 1", bus.ack0);
        end
        await_ack(gp, gh, ge, ok);
        e = sbq.pop_front();
        vectors++;
        if (!ok || gp != e.port || gh !== e.hit || ge !== e.err) begin
            miscompares++;
            $display("FAIL hit_rsp: got ok=%0d port=%0d hit=%b err=%b, want port=%0d hit=%b err=%b",
                     ok, gp, gh, ge, e.port, e.hit, e.err);
        end
        bus.req0 = 1'b0;
        tick();
        vectors++;
        if (bus.access_cnt !== CNT_W'(exp_acc) || bus.hit_cnt !== CNT_W'(exp_hit) || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL hit_counters: got %0d/%0d busy=%b, want %0d/%0d busy=0",
                     bus.access_cnt, bus.hit_cnt, bus.busy, exp_acc, exp_hit);
        end
    endtask

    task automatic test_miss();
        int gp; logic gh, ge; bit ok; exp_t e;
        bus.addr1 = 15'h3008; bus.req1 = 1'b1;
        push_exp(1, 1'b0, 1'b0);
        tick();
        for (int i = 1; i <= 6; i++) begin
            vectors++;
            if (bus.sub_req !== 1'b1 || bus.sub_addr !== 15'h3008) begin
                miscompares++;
                $display("FAIL miss_addr_hold: cycle %0d got sub_req=%b sub_addr=%h, want 1 3008",
                         i, bus.sub_req, bus.sub_addr);
            end
            bus.addr0 = 15'(i * 273);
            if (i == 6) begin
                bus.sub_done = 1'b1; bus.sub_hit = 1'b0;
            end
            tick();
        end
        bus.sub_done = 1'b0;
        vectors++;
        if (bus.ack1 !== 1'b1) begin
            miscompares++;
            $display("FAIL miss_ack_latency: got ack1=%b one cycle after sub_done, want 1", bus.ack1);
        end
        await_ack(gp, gh, ge, ok);
        e = sbq.pop_front();
        vectors++;
        if (!ok || gp != e.port || gh !== e.hit || ge !== e.err) begin
            miscompares++;
            $display("FAIL miss_rsp: got ok=%0d port=%0d hit=%b err=%b, want port=%0d hit=%b err=%b",
                     ok, gp, gh, ge, e.port, e.hit, e.err);
        end
        bus.req1 = 1'b0;
        tick();
        vectors++;
        if (bus.access_cnt !== CNT_W'(exp_acc) || bus.hit_cnt !== CNT_W'(exp_hit)) begin
            miscompares++;
            $display("FAIL miss_counters: got %0d/%0d, want %0d/%0d", bus.access_cnt, bus.hit_cnt, exp_acc, exp_hit);
        end
    endtask

    task automatic test_contention();
        int gp; logic gh, ge; bit ok; exp_t e; int ep;
        bus.addr0 = 15'h0a0a; bus.addr1 = 15'h5050;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int t = 0; t < 4; t++) begin
            ep = t % 2;
            push_exp(ep, logic'(ep), 1'b0);
            await_sub_req(ok);
            vectors++;
            if (!ok || bus.sub_addr !== ((ep == 1) ? 15'h5050 : 15'h0a0a)) begin
                miscompares++;
                $display("FAIL cont_grant_addr: txn %0d got ok=%0d sub_addr=%h, want port %0d address",
                         t, ok, bus.sub_addr, ep);
            end
            bus.sub_done = 1'b1; bus.sub_hit = logic'(ep);
            tick();
            bus.sub_done = 1'b0;
            await_ack(gp, gh, ge, ok);
            e = sbq.pop_front();
            vectors++;
            if (!ok || gp != e.port || gh !== e.hit || ge !== e.err) begin
                miscompares++;
                $display("FAIL cont_order: txn %0d got ok=%0d port=%0d hit=%b err=%b, want port=%0d hit=%b err=%b",
                         t, ok, gp, gh, ge, e.port, e.hit, e.err);
            end
            if (t == 3) begin
                bus.req0 = 1'b0; bus.req1 = 1'b0;
            end
        end
        tick();
        vectors++;
        if (bus.access_cnt !== CNT_W'(exp_acc) || bus.hit_cnt !== CNT_W'(exp_hit)) begin
            miscompares++;
            $display("FAIL cont_counters: got %0d/%0d, want %0d/%0d", bus.access_cnt, bus.hit_cnt, exp_acc, exp_hit);
        end
    endtask

    task automatic test_timeout();
        int gp; logic gh, ge; bit ok; exp_t e;
        // Subsystem never answers; sub_hit held high must not leak through.
        bus.addr0 = 15'h0555; bus.req0 = 1'b1; bus.sub_hit = 1'b1;
        push_exp(0, 1'b0, 1'b1);
        tick();
        for (int i = 1; i <= TIMEOUT; i++) begin
            if (i == 1 || i == TIMEOUT) begin
                vectors++;
                if (bus.sub_req !== 1'b1 || bus.ack0 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL tmo_busy_held: busy cycle %0d got sub_req=%b ack0=%b, want 1 0",
                             i, bus.sub_req, bus.ack0);
                end
            end
            tick();
        end
        vectors++;
        if (bus.ack0 !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_ack_time: got ack0=%b after %0d busy cycles, want 1", bus.ack0, TIMEOUT);
        end
        await_ack(gp, gh, ge, ok);
        e = sbq.pop_front();
        vectors++;
        if (!ok || gp != e.port || gh !== e.hit || ge !== e.err) begin
            miscompares++;
            $display("FAIL tmo_rsp: got ok=%0d port=%0d hit=%b err=%b, want port=%0d hit=%b err=%b",
                     ok, gp, gh, ge, e.port, e.hit, e.err);
        end
        bus.req0 = 1'b0; bus.sub_hit = 1'b0;
        tick();
        vectors++;
        if (bus.access_cnt !== CNT_W'(exp_acc) || bus.hit_cnt !== CNT_W'(exp_hit)) begin
            miscompares++;
            $display("FAIL tmo_counters: got %0d/%0d, want %0d/%0d", bus.access_cnt, bus.hit_cnt, exp_acc, exp_hit);
        end

        // Same again, with sub_done arriving in the very last busy cycle.
        bus.req0 = 1'b1;
        push_exp(0, 1'b1, 1'b0);
        tick();
        for (int i = 1; i <= TIMEOUT; i++) begin
            if (i == TIMEOUT) begin
                bus.sub_done = 1'b1; bus.sub_hit = 1'b1;
            end
            tick();
        end
        bus.sub_done = 1'b0; bus.sub_hit = 1'b0;
        await_ack(gp, gh, ge, ok);
        e = sbq.pop_front();
        vectors++;
        if (!ok || gp != e.port || gh !== e.hit || ge !== e.err) begin
            miscompares++;
            $display("FAIL tmo_done_wins: got ok=%0d port=%0d hit=%b err=%b, want port=%0d hit=%b err=%b",
                     ok, gp, gh, ge, e.port, e.hit, e.err);
        end
        bus.req0 = 1'b0;
        tick();
        vectors++;
        if (bus.access_cnt !== CNT_W'(exp_acc) || bus.hit_cnt !== CNT_W'(exp_hit)) begin
            miscompares++;
            $display("FAIL tmo_done_counters: got %0d/%0d, want %0d/%0d", bus.access_cnt, bus.hit_cnt, exp_acc, exp_hit);
        end
    endtask

    task automatic test_idle_done();
        for (int i = 0; i < 3; i++) begin
            bus.sub_done = 1'b1; bus.sub_hit = 1'b1;
            tick();
            vectors++;
            if (bus.busy !== 1'b0 || bus.sub_req !== 1'b0 || bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 ||
                bus.access_cnt !== CNT_W'(exp_acc) || bus.hit_cnt !== CNT_W'(exp_hit)) begin
                miscompares++;
                $display("FAIL idle_done_ignored: got busy=%b sub_req=%b ack=%b%b cnt=%0d/%0d, want 0 0 00 %0d/%0d",
                         bus.busy, bus.sub_req, bus.ack0, bus.ack1, bus.access_cnt, bus.hit_cnt, exp_acc, exp_hit);
            end
        end
        bus.sub_done = 1'b0; bus.sub_hit = 1'b0;
    endtask

    task automatic test_saturation();
        int gp; logic gh, ge; bit ok; exp_t e;
        bus.clr_stats = 1'b1;
        tick();
        bus.clr_stats = 1'b0;
        exp_acc = 0; exp_hit = 0;
        vectors++;
        if (bus.access_cnt !== 4'h0 || bus.hit_cnt !== 4'h0) begin
            miscompares++;
            $display("FAIL clr_counters: got %0d/%0d, want 0/0", bus.access_cnt, bus.hit_cnt);
        end
        for (int k = 1; k <= 18; k++) begin
            bus.addr0 = 15'(k); bus.req0 = 1'b1;
            push_exp(0, 1'b1, 1'b0);
            await_sub_req(ok);
            bus.sub_done = 1'b1; bus.sub_hit = 1'b1;
            tick();
            bus.sub_done = 1'b0; bus.sub_hit = 1'b0;
            await_ack(gp, gh, ge, ok);
            e = sbq.pop_front();
            vectors++;
            if (!ok || gp != e.port || gh !== e.hit || ge !== e.err) begin
                miscompares++;
                $display("FAIL sat_rsp: hit %0d got ok=%0d port=%0d hit=%b err=%b, want port=%0d hit=%b err=%b",
                         k, ok, gp, gh, ge, e.port, e.hit, e.err);
            end
            bus.req0 = 1'b0;
            if (k == 18) begin
                bus.clr_stats = 1'b1;
                exp_acc = 0; exp_hit = 0;
            end
            tick();
            bus.clr_stats = 1'b0;
            vectors++;
            if (bus.access_cnt !== CNT_W'(exp_acc) || bus.hit_cnt !== CNT_W'(exp_hit)) begin
                miscompares++;
                $display("FAIL sat_counters: after hit %0d got %0d/%0d, want %0d/%0d",
                         k, bus.access_cnt, bus.hit_cnt, exp_acc, exp_hit);
            end
        end
    endtask

    initial begin
        bus.req0 = 1'b0; bus.addr0 = '0;
        bus.req1 = 1'b0; bus.addr1 = '0;
        bus.sub_done = 1'b0; bus.sub_hit = 1'b0; bus.clr_stats = 1'b0;
        test_reset();
        test_single_hit();
        test_miss();
        test_contention();
        test_timeout();
        test_idle_done();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
